// File: rtl/spi_regfile.sv
// SPI mode-0 register-file peripheral: synchronised pins, write commit with
// framing validation, and register read-back on cipo during the data phase.
module spi_regfile #(
  parameter int unsigned       NUM_REGS    = 5,
  parameter int unsigned       DATA_W      = 8,
  parameter int unsigned       ADDR_W      = 7,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] RESET_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         copi,
  input  logic                         ncs,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_pulse,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err
);

  localparam int unsigned      FRAME_LEN  = 1 + ADDR_W + DATA_W;
  localparam int unsigned      CNT_W      = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]  NUM_REGS_W = (ADDR_W + 1)'(NUM_REGS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_FULL,
    ST_OVER
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] copi_sync_q, copi_sync_d;
  logic [SYNC_STAGES-1:0] ncs_sync_q,  ncs_sync_d;
  logic                   sclk_dly_q,  sclk_dly_d;
  logic                   ncs_dly_q,   ncs_dly_d;

  state_e                            state_q, state_d;
  logic [CNT_W-1:0]                  cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]              frame_q, frame_d;
  logic [DATA_W-1:0]                 sout_q, sout_d;
  logic                              first_fall_q, first_fall_d;
  logic                              cipo_oe_q, cipo_oe_d;
  logic [NUM_REGS-1:0][DATA_W-1:0]   regs_q, regs_d;
  logic                              wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0]                 wr_addr_q, wr_addr_d;
  logic                              frame_err_q, frame_err_d;

  logic                 sclk_s, copi_s, ncs_s;
  logic                 sclk_rise, sclk_fall, ncs_rise, ncs_fall;
  logic [FRAME_LEN-1:0] frame_shift;
  logic [ADDR_W-1:0]    rd_addr;
  logic [DATA_W-1:0]    rd_word;
  logic                 f_rw;
  logic [ADDR_W-1:0]    f_addr;
  logic [DATA_W-1:0]    f_data;
  logic                 f_addr_ok;

  always_comb begin
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
    copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], copi};
    ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], ncs};
    sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
    ncs_dly_d   = ncs_sync_q[SYNC_STAGES-1];
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ncs_rise  = ncs_s & ~ncs_dly_q;
  assign ncs_fall  = ~ncs_s & ncs_dly_q;

  // Frame word is {rw, addr, data}; the address is taken from the shifted
  // value so the read-back word is fetched on the edge of the last address bit.
  assign frame_shift = {frame_q[FRAME_LEN-2:0], copi_s};
  assign rd_addr     = frame_shift[ADDR_W-1:0];
  assign f_rw        = frame_q[FRAME_LEN-1];
  assign f_addr      = frame_q[DATA_W +: ADDR_W];
  assign f_data      = frame_q[DATA_W-1:0];
  assign f_addr_ok   = {1'b0, f_addr} < NUM_REGS_W;

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == ADDR_W'(k)) rd_word = regs_q[k];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    frame_d      = frame_q;
    sout_d       = sout_q;
    first_fall_d = first_fall_q;
    cipo_oe_d    = cipo_oe_q;
    regs_d       = regs_q;
    wr_pulse_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    frame_err_d  = 1'b0;

    if (ncs_fall) begin
      state_d   = ST_CMD;
      cnt_d     = '0;
      frame_d   = '0;
      cipo_oe_d = 1'b0;
    end else if (ncs_rise) begin
      if (state_q != ST_IDLE) begin
        state_d   = ST_IDLE;
        cipo_oe_d = 1'b0;
        if (state_q == ST_FULL) begin
          if (f_rw) begin
            if (f_addr_ok) begin
              for (int unsigned k = 0; k < NUM_REGS; k++) begin
                if (f_addr == ADDR_W'(k)) regs_d[k] = f_data;
              end
              wr_pulse_d = 1'b1;
              wr_addr_d  = f_addr;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end else begin
          frame_err_d = 1'b1;
        end
      end
    end else begin
      case (state_q)
        ST_CMD: begin
          if (sclk_rise) begin
            frame_d = frame_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CMD_LAST) begin
              state_d      = ST_DATA;
              first_fall_d = 1'b1;
              if (!frame_shift[ADDR_W]) begin
                cipo_oe_d = 1'b1;
                sout_d    = rd_word;
              end
            end
          end
        end
        ST_DATA: begin
          if (sclk_rise) begin
            frame_d = frame_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == DATA_LAST) state_d = ST_FULL;
          end else if (sclk_fall) begin
            // MSB is already on cipo for the first data sample, so hold once.
            if (first_fall_q) first_fall_d = 1'b0;
            else              sout_d       = sout_q << 1;
          end
        end
        ST_FULL: begin
          if (sclk_rise) begin
            state_d   = ST_OVER;
            cipo_oe_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q  <= '0;
      copi_sync_q  <= '0;
      ncs_sync_q   <= '1;
      sclk_dly_q   <= 1'b0;
      ncs_dly_q    <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      frame_q      <= '0;
      sout_q       <= '0;
      first_fall_q <= 1'b0;
      cipo_oe_q    <= 1'b0;
      regs_q       <= {NUM_REGS{RESET_VAL}};
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      sclk_sync_q  <= sclk_sync_d;
      copi_sync_q  <= copi_sync_d;
      ncs_sync_q   <= ncs_sync_d;
      sclk_dly_q   <= sclk_dly_d;
      ncs_dly_q    <= ncs_dly_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      frame_q      <= frame_d;
      sout_q       <= sout_d;
      first_fall_q <= first_fall_d;
      cipo_oe_q    <= cipo_oe_d;
      regs_q       <= regs_d;
      wr_pulse_q   <= wr_pulse_d;
      wr_addr_q    <= wr_addr_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign cipo      = cipo_oe_q & sout_q[DATA_W-1];
  assign cipo_oe   = cipo_oe_q;
  assign regs_flat = regs_q;
  assign wr_pulse  = wr_pulse_q;
  assign wr_addr   = wr_addr_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile.sv
// Directed bench for spi_regfile: default instance (a) and a wide instance (b)
// with 8 x 16-bit registers and 3-stage synchronisers.
module tb_spi_regfile;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk_a = 1'b0, copi_a = 1'b0, ncs_a = 1'b1;
  logic sclk_b = 1'b0, copi_b = 1'b0, ncs_b = 1'b1;

  logic         cipo_a, oe_a, wrp_a, ferr_a;
  logic [39:0]  regs_a;
  logic [6:0]   wa_a;
  logic         cipo_b, oe_b, wrp_b, ferr_b;
  logic [127:0] regs_b;
  logic [6:0]   wa_b;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_regfile dut_a (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_a), .copi(copi_a), .ncs(ncs_a),
    .cipo(cipo_a), .cipo_oe(oe_a), .regs_flat(regs_a), .wr_pulse(wrp_a),
    .wr_addr(wa_a), .frame_err(ferr_a)
  );

  spi_regfile #(.NUM_REGS(8), .DATA_W(16), .SYNC_STAGES(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .sclk(sclk_b), .copi(copi_b), .ncs(ncs_b),
    .cipo(cipo_b), .cipo_oe(oe_b), .regs_flat(regs_b), .wr_pulse(wrp_b),
    .wr_addr(wa_b), .frame_err(ferr_b)
  );

  task automatic start_frame(input int sel);
    @(negedge clk);
    if (sel == 0) ncs_a = 1'b0; else ncs_b = 1'b0;
    #80;
  endtask

  task automatic shift_bits(input int sel, input int nbits, input logic [31:0] bits,
                            output logic [31:0] rx, output logic [31:0] oe);
    rx = '0;
    oe = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      if (sel == 0) copi_a = bits[i]; else copi_b = bits[i];
      #40;
      rx = {rx[30:0], (sel == 0) ? cipo_a : cipo_b};
      oe = {oe[30:0], (sel == 0) ? oe_a : oe_b};
      if (sel == 0) sclk_a = 1'b1; else sclk_b = 1'b1;
      #40;
      if (sel == 0) sclk_a = 1'b0; else sclk_b = 1'b0;
    end
  endtask

  task automatic end_frame(input int sel, input int sync, output int np, output int ne,
                           output logic [6:0] wa, output logic [127:0] regs_at);
    #40;
    if (sel == 0) ncs_a = 1'b1; else ncs_b = 1'b1;
    np = 0;
    ne = 0;
    wa = '0;
    regs_at = '0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if ((sel == 0) ? wrp_a : wrp_b) begin
        np++;
        wa = (sel == 0) ? wa_a : wa_b;
      end
      if ((sel == 0) ? ferr_a : ferr_b) ne++;
      if (c == sync + 2) regs_at = (sel == 0) ? {88'h0, regs_a} : regs_b;
    end
  endtask

  task automatic test_reset();
    #23;
    checks++; if (regs_a !== 40'h0) begin failures++; $display("FAIL reset_regs_a got=%h exp=0", regs_a); end
    checks++; if (regs_b !== 128'h0) begin failures++; $display("FAIL reset_regs_b got=%h exp=0", regs_b); end
    checks++; if ({cipo_a, oe_a, wrp_a, ferr_a} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes_a got=%b exp=0000", {cipo_a, oe_a, wrp_a, ferr_a}); end
    checks++; if (wa_a !== 7'd0) begin failures++; $display("FAIL reset_wr_addr got=%0d exp=0", wa_a); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic [31:0] rx, oe; logic [127:0] r; logic [6:0] wa; int np, ne;
    start_frame(0);
    shift_bits(0, 16, 32'h82A5, rx, oe);
    end_frame(0, 2, np, ne, wa, r);
    checks++; if (r[39:0] !== 40'h0000A50000) begin failures++; $display("FAIL write_regs got=%h exp=0000a50000", r[39:0]); end
    checks++; if (np !== 1) begin failures++; $display("FAIL write_pulse_count got=%0d exp=1", np); end
    checks++; if (ne !== 0) begin failures++; $display("FAIL write_err_count got=%0d exp=0", ne); end
    checks++; if (wa !== 7'd2) begin failures++; $display("FAIL write_wr_addr got=%0d exp=2", wa); end
    checks++; if (oe[15:0] !== 16'h0) begin failures++; $display("FAIL write_oe got=%h exp=0000", oe[15:0]); end
  endtask

  task automatic test_read();
    logic [31:0] rx, oe; logic [127:0] r; logic [6:0] wa; int np, ne;
    start_frame(0);
    shift_bits(0, 16, 32'h0200, rx, oe);
    end_frame(0, 2, np, ne, wa, r);
    checks++; if (rx[15:0] !== 16'h00A5) begin failures++; $display("FAIL read_cipo got=%h exp=00a5", rx[15:0]); end
    checks++; if (oe[15:0] !== 16'h00FF) begin failures++; $display("FAIL read_oe got=%h exp=00ff", oe[15:0]); end
    checks++; if ({np, ne} !== {32'd0, 32'd0}) begin failures++; $display("FAIL read_strobes got=%0d/%0d exp=0/0", np, ne); end
    checks++; if ({oe_a, cipo_a} !== 2'b00) begin failures++; $display("FAIL read_oe_after got=%b exp=00", {oe_a, cipo_a}); end
    checks++; if (r[39:0] !== 40'h0000A50000) begin failures++; $display("FAIL read_regs got=%h exp=0000a50000", r[39:0]); end
  endtask

  task automatic test_bad_length();
    logic [31:0] rx, oe; logic [127:0] r; logic [6:0] wa; int np, ne;
    start_frame(0);
    shift_bits(0, 15, 32'h407F, rx, oe);
    end_frame(0, 2, np, ne, wa, r);
    checks++; if ({np, ne} !== {32'd0, 32'd1}) begin failures++; $display("FAIL short_strobes got=%0d/%0d exp=0/1", np, ne); end
    checks++; if (r[39:0] !== 40'h0000A50000) begin failures++; $display("FAIL short_regs got=%h exp=0000a50000", r[39:0]); end
    start_frame(0);
    shift_bits(0, 17, 32'h100AB, rx, oe);
    end_frame(0, 2, np, ne, wa, r);
    checks++; if ({np, ne} !== {32'd0, 32'd1}) begin failures++; $display("FAIL long_strobes got=%0d/%0d exp=0/1", np, ne); end
    checks++; if (r[39:0] !== 40'h0000A50000) begin failures++; $display("FAIL long_regs got=%h exp=0000a50000", r[39:0]); end
  endtask

  task automatic test_bad_addr();
    logic [31:0] rx, oe; logic [127:0] r; logic [6:0] wa; int np, ne;
    start_frame(0);
    shift_bits(0, 16, 32'h87FF, rx, oe);
    end_frame(0, 2, np, ne, wa, r);
    checks++; if ({np, ne} !== {32'd0, 32'd1}) begin failures++; $display("FAIL badaddr_strobes got=%0d/%0d exp=0/1", np, ne); end
    checks++; if (r[39:0] !== 40'h0000A50000) begin failures++; $display("FAIL badaddr_regs got=%h exp=0000a50000", r[39:0]); end
    start_frame(0);
    shift_bits(0, 16, 32'h0700, rx, oe);
    end_frame(0, 2, np, ne, wa, r);
    checks++; if (rx[15:0] !== 16'h0000) begin failures++; $display("FAIL badaddr_read_cipo got=%h exp=0000", rx[15:0]); end
    checks++; if (oe[15:0] !== 16'h00FF) begin failures++; $display("FAIL badaddr_read_oe got=%h exp=00ff", oe[15:0]); end
    checks++; if ({np, ne} !== {32'd0, 32'd0}) begin failures++; $display("FAIL badaddr_read_strobes got=%0d/%0d exp=0/0", np, ne); end
    checks++; if (wa_a !== 7'd2) begin failures++; $display("FAIL badaddr_wr_addr got=%0d exp=2", wa_a); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rx, oe; logic [127:0] r; logic [6:0] wa; int np, ne;
    start_frame(0);
    shift_bits(0, 10, 32'h210, rx, oe);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (regs_a !== 40'h0) begin failures++; $display("FAIL midreset_regs got=%h exp=0", regs_a); end
    checks++; if ({oe_a, wa_a} !== 8'h00) begin failures++; $display("FAIL midreset_oe_addr got=%b/%0d exp=0/0", oe_a, wa_a); end
    ncs_a = 1'b1;
    copi_a = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    np = 0;
    ne = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (wrp_a) np++;
      if (ferr_a) ne++;
    end
    checks++; if ({np, ne} !== {32'd0, 32'd0}) begin failures++; $display("FAIL midreset_strobes got=%0d/%0d exp=0/0", np, ne); end
    start_frame(0);
    shift_bits(0, 16, 32'h843C, rx, oe);
    end_frame(0, 2, np, ne, wa, r);
    checks++; if (r[39:0] !== 40'h3C00000000) begin failures++; $display("FAIL postreset_regs got=%h exp=3c00000000", r[39:0]); end
    checks++; if ({np, wa} !== {32'd1, 7'd4}) begin failures++; $display("FAIL postreset_pulse got=%0d/%0d exp=1/4", np, wa); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rx, oe; logic [127:0] r; logic [6:0] wa; int np, ne;
    start_frame(0);
    shift_bits(0, 16, 32'h8111, rx, oe);
    end_frame(0, 2, np, ne, wa, r);
    checks++; if ({np, wa} !== {32'd1, 7'd1}) begin failures++; $display("FAIL b2b_first got=%0d/%0d exp=1/1", np, wa); end
    start_frame(0);
    shift_bits(0, 16, 32'h8333, rx, oe);
    end_frame(0, 2, np, ne, wa, r);
    checks++; if ({np, wa} !== {32'd1, 7'd3}) begin failures++; $display("FAIL b2b_second got=%0d/%0d exp=1/3", np, wa); end
    checks++; if (r[39:0] !== 40'h3C33001100) begin failures++; $display("FAIL b2b_regs got=%h exp=3c33001100", r[39:0]); end
  endtask

  task automatic test_wide();
    logic [31:0] rx, oe; logic [127:0] r; logic [6:0] wa; int np, ne;
    start_frame(1);
    shift_bits(1, 24, 32'h87BEEF, rx, oe);
    end_frame(1, 3, np, ne, wa, r);
    checks++; if (r !== {16'hBEEF, 112'h0}) begin failures++; $display("FAIL wide_regs got=%h exp=beef<<112", r); end
    checks++; if ({np, ne, wa} !== {32'd1, 32'd0, 7'd7}) begin
      failures++; $display("FAIL wide_strobes got=%0d/%0d/%0d exp=1/0/7", np, ne, wa); end
    start_frame(1);
    shift_bits(1, 24, 32'h070000, rx, oe);
    end_frame(1, 3, np, ne, wa, r);
    checks++; if (rx[23:0] !== 24'h00BEEF) begin failures++; $display("FAIL wide_read_cipo got=%h exp=00beef", rx[23:0]); end
    checks++; if (oe[23:0] !== 24'h00FFFF) begin failures++; $display("FAIL wide_read_oe got=%h exp=00ffff", oe[23:0]); end
    checks++; if (regs_a !== 40'h3C33001100) begin failures++; $display("FAIL wide_isolation got=%h exp=3c33001100", regs_a); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_length();
    test_bad_addr();
    test_reset_mid_frame();
    test_back_to_back();
    test_wide();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
